ternary_serial_addsub: RTL
==========================

TERNARY_SERIAL_ADDSUB -- requirements
Module: ternary_serial_addsub

Interface
REQ-001 SHALL have parameter N, default 4, number of ternary digits per operand (N >= 1).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port sub  input  1  0 = a+b, 1 = a-b; sampled with start.
REQ-006 SHALL have port a  input  2N  minuend/addend; digit i on bits [2i+1:2i]; code 00=0, 01=1, 10=2, 11 illegal.
REQ-007 SHALL have port b  input  2N  subtrahend/addend; same digit encoding as a.
REQ-008 SHALL have port busy  output  1  high while in RUN.
REQ-009 SHALL have port done  output  1  one-cycle pulse, high only in DONE.
REQ-010 SHALL have port result  output  2N  sum/difference mod 3^N, same digit encoding.
REQ-011 SHALL have port cout  output  1  final carry; for sub, 1 = no borrow (a >= b).
REQ-012 SHALL have port err  output  1  high if any sampled digit of a or b was code 11.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 IDLE: start=1 at a clock edge SHALL latch a, b, sub, clear digit counter, go to RUN; start=0 stays IDLE.
REQ-015 On latch with sub=1, the b register SHALL hold the digit-wise diminished complement of b (digit d -> 2-d: 00->10, 01->01, 10->00) and the carry register SHALL be 1; with sub=0, b unchanged and carry 0.
REQ-016 RUN: each edge SHALL process one digit, LSB digit (index 0) first: s = a_i + b_i + c (0..5); digit = s mod 3; c = (s >= 3).
REQ-017 Each processed digit SHALL be shifted into result from the MSB digit position, result shifting right one digit, so after N digits digit i sits at bits [2i+1:2i].
REQ-018 After the N-th RUN edge the FSM SHALL enter DONE; cout SHALL equal final carry.
REQ-019 DONE SHALL last exactly one cycle, then return to IDLE unconditionally; start during DONE SHALL be ignored.
REQ-020 Latency: start sampled at edge k -> busy high cycles k+1..k+N, done high in cycle k+N+1.
REQ-021 start during RUN or DONE SHALL be ignored with no effect on operands or result.
REQ-022 result, cout, err SHALL be held stable in DONE and IDLE until the next accepted start; intermediate result values during RUN are undefined to consumers.
REQ-023 Illegal code 11 in a or b SHALL be treated as digit 0 (before complement) and SHALL set err, latched at start and held until next accepted start.
REQ-024 Digit counter SHALL be ceil(log2(N+1)) bits minimum and SHALL not wrap within one operation.
REQ-025 Overflow beyond N digits SHALL be reported only through cout; result wraps mod 3^N.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, result=all 00, cout=0, err=0, counter=0, carry=0.
REQ-027 rst_n asserted during RUN SHALL abort the operation; no done pulse SHALL follow release.
REQ-028 After rst_n release the first edge with start=1 SHALL be accepted normally.

Verification (N=4, digits written MSB..LSB)
REQ-029 add a=0012 (5), b=0001 (1) -> done 5 cycles after start edge, result=0020 (6), cout=0, err=0.
REQ-030 sub a=0012, b=0001 -> result=0011 (4), cout=1.
REQ-031 sub a=0001, b=0012 -> result=2212 (77 = 81-4), cout=0.
REQ-032 add a=2222, b=0001 -> result=0000, cout=1; start re-pulsed during RUN ignored, exactly one done pulse.
REQ-033 a digit 1 = code 11, b=0000, add -> err=1, that digit treated as 0, result=0000.
REQ-034 rst_n low at cycle 2 of RUN -> outputs at reset values immediately, no done; next start runs to correct result.

Source files
------------

// File: rtl/ternary_serial_addsub.sv
// Bit-serial ternary adder/subtractor: one base-3 digit per clock, LSB first.
// Subtraction adds the digit-wise diminished complement of b with an initial carry of 1.
module ternary_serial_addsub #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           sub,
  input  logic [2*N-1:0] a,
  input  logic [2*N-1:0] b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] result,
  output logic           cout,
  output logic           err
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state, w_next;
  logic [2*N-1:0]   r_a, r_b, r_res;
  logic [2*N-1:0]   w_a_clean, w_b_eff, w_ins;
  logic [CW-1:0]    r_cnt;
  logic             r_carry, r_err;
  logic             w_any_bad, w_last, w_cy;
  logic [2:0]       w_sum;
  logic [1:0]       w_digit;

  // Code 11 reads as digit 0; subtraction complements after that cleanup.
  always_comb begin
    w_any_bad = 1'b0;
    w_a_clean = '0;
    w_b_eff   = '0;
    for (int i = 0; i < N; i++) begin
      w_a_clean[2*i +: 2] = (a[2*i +: 2] == 2'b11) ? 2'b00 : a[2*i +: 2];
      w_b_eff[2*i +: 2]   = (b[2*i +: 2] == 2'b11) ? 2'b00 : b[2*i +: 2];
      if (sub)
        w_b_eff[2*i +: 2] = 2'b10 - w_b_eff[2*i +: 2];
      w_any_bad = w_any_bad | (a[2*i +: 2] == 2'b11) | (b[2*i +: 2] == 2'b11);
    end
  end

  assign w_sum   = {1'b0, r_a[1:0]} + {1'b0, r_b[1:0]} + {2'b00, r_carry};
  assign w_cy    = (w_sum >= 3'd3);
  assign w_digit = w_cy ? 2'(w_sum - 3'd3) : w_sum[1:0];
  assign w_ins   = (2*N)'(w_digit) << (2*N - 2);
  assign w_last  = (r_cnt == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_err   <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_a     <= w_a_clean;
      r_b     <= w_b_eff;
      r_carry <= sub;
      r_err   <= w_any_bad;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> 2;
      r_b     <= r_b >> 2;
      r_res   <= (r_res >> 2) | w_ins;
      r_carry <= w_cy;
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  assign busy   = (r_state == RUN);
  assign done   = (r_state == DONE);
  assign result = r_res;
  assign cout   = r_carry;
  assign err    = r_err;
endmodule
